// File: rtl/fll_rate_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fll_rate_ctrl
// Brief   : I2S FLL sequencing controller. Tracks master-minus-local word
//           drift and raises speedup/slowdown requests with clear + holdoff.
// Revision: 1.0 - initial release
// ============================================================================
module fll_rate_ctrl #(
  parameter int DIFF_W = 8,
  parameter int HOLD_W = 16
) (
  input  logic                     CLK_IP_i,
  input  logic                     RST_IP_i,
  input  logic                     enable_i,
  input  logic                     master_word_i,
  input  logic                     local_word_i,
  input  logic [DIFF_W-2:0]        threshold_i,
  input  logic [HOLD_W-1:0]        holdoff_i,
  input  logic                     int_clr_i,
  output logic                     Interrupt_speedup_o,
  output logic                     Interrupt_slowdown_o,
  output logic signed [DIFF_W-1:0] word_diff_o,
  output logic                     master_wordcnt_is_ahead_o,
  output logic                     local_wordcnt_is_ahead_o,
  output logic [2:0]               state_o
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TRACK    = 3'd1,
    ST_SPEEDUP  = 3'd2,
    ST_SLOWDOWN = 3'd3,
    ST_HOLDOFF  = 3'd4
  } state_t;

  // Symmetric saturation limits: +(2^(N-1)-1) and -(2^(N-1)-1).
  localparam logic signed [DIFF_W-1:0] C_DIFF_MAX = {1'b0, {(DIFF_W-1){1'b1}}};
  localparam logic signed [DIFF_W-1:0] C_DIFF_MIN = -C_DIFF_MAX;
  localparam logic signed [DIFF_W-1:0] C_DIFF_ONE = DIFF_W'(1);
  localparam logic [DIFF_W-2:0]        C_THR_ONE  = (DIFF_W-1)'(1);
  localparam logic [HOLD_W-1:0]        C_HOLD_ONE = HOLD_W'(1);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic signed [DIFF_W-1:0]   r_diff;
  logic [HOLD_W-1:0]          r_hcnt;
  logic [DIFF_W-2:0]          w_thr_u;
  logic signed [DIFF_W-1:0]   w_thr;
  logic signed [DIFF_W-1:0]   w_neg_thr;
  logic                       w_in_req;
  logic                       w_clr_take;

  assign w_thr_u    = (threshold_i == '0) ? C_THR_ONE : threshold_i;
  assign w_thr      = {1'b0, w_thr_u};
  assign w_neg_thr  = -w_thr;
  assign w_in_req   = (r_state == ST_SPEEDUP) || (r_state == ST_SLOWDOWN);
  assign w_clr_take = w_in_req && int_clr_i && enable_i;

  always_ff @(posedge CLK_IP_i) begin
    if (RST_IP_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (enable_i) w_state_nxt = ST_TRACK;
      ST_TRACK: begin
        if (r_diff >= w_thr)          w_state_nxt = ST_SPEEDUP;
        else if (r_diff <= w_neg_thr) w_state_nxt = ST_SLOWDOWN;
      end
      ST_SPEEDUP,
      ST_SLOWDOWN: if (int_clr_i) w_state_nxt = ST_HOLDOFF;
      ST_HOLDOFF:  if (r_hcnt == '0) w_state_nxt = ST_TRACK;
      default:     w_state_nxt = ST_IDLE;
    endcase
    // Disable overrides everything, including a pending request or clear.
    if (!enable_i) w_state_nxt = ST_IDLE;
  end

  // diff is zeroed on the same edge the FSM falls back to IDLE.
  always_ff @(posedge CLK_IP_i) begin
    if (RST_IP_i) begin
      r_diff <= '0;
    end else if ((r_state == ST_IDLE) || !enable_i) begin
      r_diff <= '0;
    end else if (master_word_i && !local_word_i) begin
      if (r_diff != C_DIFF_MAX) r_diff <= r_diff + C_DIFF_ONE;
    end else if (local_word_i && !master_word_i) begin
      if (r_diff != C_DIFF_MIN) r_diff <= r_diff - C_DIFF_ONE;
    end
  end

  always_ff @(posedge CLK_IP_i) begin
    if (RST_IP_i) begin
      r_hcnt <= '0;
    end else if (w_clr_take) begin
      r_hcnt <= holdoff_i;
    end else if ((r_state == ST_HOLDOFF) && (r_hcnt != '0)) begin
      r_hcnt <= r_hcnt - C_HOLD_ONE;
    end
  end

  assign Interrupt_speedup_o       = (r_state == ST_SPEEDUP);
  assign Interrupt_slowdown_o      = (r_state == ST_SLOWDOWN);
  assign word_diff_o               = r_diff;
  assign master_wordcnt_is_ahead_o = !r_diff[DIFF_W-1] && (r_diff != '0);
  assign local_wordcnt_is_ahead_o  = r_diff[DIFF_W-1];
  assign state_o                   = r_state;

endmodule
`default_nettype wire
